// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types, counter constants and counter update helper for branch_unit
//
// Contents:
//   br_type_e  : branch type encoding (BR_EQ .. BR_NONE, values 0-7)
//   CNT_*      : 2-bit saturating counter reset/limit values
//   next_cnt() : saturating increment on taken, saturating decrement on not taken
package branch_pkg;

  typedef enum logic [2:0] {
    BR_EQ   = 3'd0,
    BR_NE   = 3'd1,
    BR_LT   = 3'd2,
    BR_GE   = 3'd3,
    BR_LTU  = 3'd4,
    BR_GEU  = 3'd5,
    BR_JAL  = 3'd6,
    BR_NONE = 3'd7
  } br_type_e;

  localparam logic [1:0] CNT_RESET = 2'b01;
  localparam logic [1:0] CNT_MAX   = 2'b11;
  localparam logic [1:0] CNT_MIN   = 2'b00;

  function automatic logic [1:0] next_cnt(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken) begin
      if (cnt != CNT_MAX) res = cnt + 2'd1;
    end else begin
      if (cnt != CNT_MIN) res = cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// rtl/branch_cmp.sv - combinational branch condition evaluation
//
// Ports:
//   rdata1, rdata2 : XLEN-bit operands
//   br_type        : branch type (see branch_pkg::br_type_e)
//   taken          : resolved direction (JAL/JALR always taken, none never taken)
module branch_cmp #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  input  logic [2:0]      br_type,
  output logic            taken
);
  import branch_pkg::*;

  always_comb begin
    taken = 1'b0;
    case (br_type_e'(br_type))
      BR_EQ:   taken = (rdata1 == rdata2);
      BR_NE:   taken = (rdata1 != rdata2);
      BR_LT:   taken = ($signed(rdata1) <  $signed(rdata2));
      BR_GE:   taken = ($signed(rdata1) >= $signed(rdata2));
      BR_LTU:  taken = (rdata1 <  rdata2);
      BR_GEU:  taken = (rdata1 >= rdata2);
      BR_JAL:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - branch resolution with registered result, handshake and optional BHT
//
// Optional feature macro: BRANCH_UNIT_BHT_EN (builds the 2-bit counter table;
// without it fetch_pred_taken is 0 and pred_taken is ignored).
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   fetch_pc            : PC being fetched; fetch_pred_taken is its combinational prediction
//   in_valid / in_ready : request handshake (rdata1, rdata2, br_type, pc, target, pred_taken)
//   flush               : kills the held result and blocks acceptance this cycle
//   out_valid/out_ready : result handshake (br_taken, mispredict, redirect_pc)
module branch_unit #(
  parameter int XLEN      = 32,
  parameter int BHT_DEPTH = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            fetch_pred_taken,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  input  logic [2:0]      br_type,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] target,
  input  logic            pred_taken,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            br_taken,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
);
  import branch_pkg::*;

  logic accept;
  logic cmp_taken;
  logic pred_eff;
  logic unused_bits;

  // Reset clears out_valid, so the unit reports ready while reset is held.
  assign in_ready = rst || !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush && !rst;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .rdata1  (rdata1),
    .rdata2  (rdata2),
    .br_type (br_type),
    .taken   (cmp_taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      br_taken    <= 1'b0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      br_taken    <= cmp_taken;
      mispredict  <= cmp_taken ^ pred_eff;
      redirect_pc <= cmp_taken ? target : pc + XLEN'(4);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef BRANCH_UNIT_BHT_EN
  localparam int IDX = $clog2(BHT_DEPTH);

  logic [1:0]     bht [BHT_DEPTH];
  logic [IDX-1:0] upd_idx;
  logic [IDX-1:0] fetch_idx;
  logic           bht_we;

  assign upd_idx   = pc[IDX+1:2];
  assign fetch_idx = fetch_pc[IDX+1:2];
  // Only conditional branches train the table; JAL/JALR and none never do.
  assign bht_we    = accept && (br_type <= 3'(BR_GEU));

  // Read is from the array directly: a same-cycle update is not bypassed.
  assign fetch_pred_taken = bht[fetch_idx][1];
  assign pred_eff         = pred_taken;
  assign unused_bits      = ^{fetch_pc[XLEN-1:IDX+2], fetch_pc[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CNT_RESET;
    end else if (bht_we) begin
      bht[upd_idx] <= next_cnt(bht[upd_idx], cmp_taken);
    end
  end
`else
  logic [$clog2(BHT_DEPTH)-1:0] unused_idx;

  assign fetch_pred_taken = 1'b0;
  assign pred_eff         = 1'b0;
  assign unused_idx       = fetch_pc[$clog2(BHT_DEPTH)+1:2];
  assign unused_bits      = ^{fetch_pc, pred_taken};
`endif

endmodule

// File: tb/tb_branch_unit.sv
// tb/tb_branch_unit.sv - randomized self-checking bench for branch_unit against a behavioural model
module tb_branch_unit;
  localparam int XLEN = 32;
  localparam int BHT  = 64;
`ifdef BRANCH_UNIT_BHT_EN
  localparam bit BHT_ON = 1'b1;
`else
  localparam bit BHT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [XLEN-1:0] fetch_pc;
  logic            fetch_pred_taken;
  logic            in_valid, in_ready;
  logic [XLEN-1:0] rdata1, rdata2, pc, target, redirect_pc;
  logic [2:0]      br_type;
  logic            pred_taken, flush, out_valid, out_ready, br_taken, mispredict;

  branch_unit #(.XLEN(XLEN), .BHT_DEPTH(BHT)) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_pc         (fetch_pc),
    .fetch_pred_taken (fetch_pred_taken),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .rdata1           (rdata1),
    .rdata2           (rdata2),
    .br_type          (br_type),
    .pc               (pc),
    .target           (target),
    .pred_taken       (pred_taken),
    .flush            (flush),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .br_taken         (br_taken),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: held result and one integer counter per table entry.
  bit              m_valid;
  bit              m_taken, m_mis;
  logic [XLEN-1:0] m_rpc;
  int              cnt [BHT];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit ref_taken(input int t, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    case (t)
      0: return a == b;
      1: return a != b;
      2: return $signed(a) <  $signed(b);
      3: return $signed(a) >= $signed(b);
      4: return a <  b;
      5: return a >= b;
      6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] pick_op();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #1;
    check("in_ready_in_reset", in_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    m_valid = 1'b0; m_taken = 1'b0; m_mis = 1'b0; m_rpc = '0;
    foreach (cnt[i]) cnt[i] = 1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_br_taken", br_taken, 1'b0);
    check("rst_mispredict", mispredict, 1'b0);
    check("rst_redirect_pc", redirect_pc, '0);
    check("rst_fetch_pred", fetch_pred_taken, 1'b0);
    @(posedge clk); #1;
  endtask

  // One clock: drive at posedge+1, check combinational outputs, step the
  // model, then check the registered outputs after the edge.
  task automatic cycle(input bit iv, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input int t, input logic [XLEN-1:0] p, input logic [XLEN-1:0] tg,
                       input bit pt, input bit fl, input bit ordy, input logic [XLEN-1:0] fpc);
    bit exp_rdy, acc, tk;
    int idx;
    in_valid = iv; rdata1 = a; rdata2 = b; br_type = 3'(t); pc = p; target = tg;
    pred_taken = pt; flush = fl; out_ready = ordy; fetch_pc = fpc;
    #1;
    exp_rdy = !m_valid || ordy;
    check("in_ready", in_ready, exp_rdy);
    check("fetch_pred", fetch_pred_taken, BHT_ON && (cnt[int'(fpc[7:2])] >= 2));
    tk  = ref_taken(t, a, b);
    acc = iv && exp_rdy && !fl;
    if (fl) m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1;
      m_taken = tk;
      m_mis   = (tk != (pt && BHT_ON));
      m_rpc   = tk ? tg : p + 4;
    end else if (ordy) m_valid = 1'b0;
    if (acc && t <= 5) begin
      idx = int'(p[7:2]);
      cnt[idx] = tk ? ((cnt[idx] < 3) ? cnt[idx] + 1 : 3) : ((cnt[idx] > 0) ? cnt[idx] - 1 : 0);
    end
    @(posedge clk); #1;
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("br_taken", br_taken, m_taken);
      check("mispredict", mispredict, m_mis);
      check("redirect_pc", redirect_pc, m_rpc);
    end
  endtask

  initial begin
    fetch_pc = '0; in_valid = 1'b0; rdata1 = '0; rdata2 = '0; br_type = '0;
    pc = '0; target = '0; pred_taken = 1'b0; flush = 1'b0; out_ready = 1'b0;
    do_reset();

    // Signed vs unsigned on the same operands, and pc+4 wrap-around.
    cycle(1, 32'hFFFF_FFFF, 32'h1, 2, 32'h204, 32'h300, 0, 0, 1, 32'h204);
    cycle(1, 32'hFFFF_FFFF, 32'h1, 4, 32'h204, 32'h300, 0, 0, 1, 32'h204);
    cycle(1, 32'h0, 32'h1, 5, 32'hFFFF_FFFC, 32'h40, 0, 0, 1, 32'h0);

    // Counter saturation up then down at index 0.
    for (int i = 0; i < 4; i++) cycle(1, 5, 5, 0, 32'h100, 32'h180, 0, 0, 1, 32'h100);
    for (int i = 0; i < 5; i++) cycle(1, 5, 5, 1, 32'h100, 32'h180, 1, 0, 1, 32'h100);

    // Back-pressure: second request waits, then loads with no bubble.
    cycle(1, 1, 2, 2, 32'h10, 32'h20, 0, 0, 1, 32'h10);
    for (int i = 0; i < 3; i++) cycle(1, 3, 3, 0, 32'h14, 32'h60, 1, 0, 0, 32'h14);
    cycle(1, 3, 3, 0, 32'h14, 32'h60, 1, 0, 1, 32'h14);
    cycle(0, 0, 0, 7, 32'h0, 32'h0, 0, 0, 1, 32'h14);

    // Flush with a held result and a taken request: no accept, no training.
    cycle(1, 7, 9, 4, 32'h30, 32'h90, 0, 0, 0, 32'h30);
    cycle(1, 4, 4, 0, 32'h140, 32'h500, 0, 1, 0, 32'h140);
    cycle(0, 0, 0, 7, 32'h0, 32'h0, 0, 0, 1, 32'h140);

    // Same-index update and lookup: old value first, new value next cycle.
    cycle(1, 4, 4, 0, 32'h144, 32'h500, 0, 0, 1, 32'h144);
    cycle(1, 4, 4, 0, 32'h144, 32'h500, 0, 0, 1, 32'h144);

    // JAL with a taken prediction; type none with a stale prediction.
    cycle(1, 0, 0, 6, 32'h400, 32'h800, 1, 0, 1, 32'h0);
    cycle(1, 0, 0, 7, 32'h404, 32'h800, 1, 0, 1, 32'h0);

    // Reset mid-stream with a stalled result, then sweep the table.
    cycle(1, 1, 1, 0, 32'h148, 32'h200, 0, 0, 0, 32'h0);
    do_reset();
    for (int i = 0; i < BHT; i++) cycle(0, 0, 0, 7, 32'h0, 32'h0, 0, 0, 1, XLEN'(i * 4));
    cycle(1, 2, 2, 0, 32'h14, 32'h60, 0, 0, 1, 32'h14);
    cycle(0, 0, 0, 7, 32'h0, 32'h0, 0, 0, 1, 32'h14);

    // Randomized traffic over a few colliding PCs.
    for (int n = 0; n < 600; n++) begin
      logic [XLEN-1:0] rp, rf;
      if ($urandom_range(0, 149) == 0) do_reset();
      rp = XLEN'($urandom_range(0, 7) * 4 + 32'h1000 * $urandom_range(0, 1));
      rf = XLEN'($urandom_range(0, 7) * 4);
      cycle($urandom_range(0, 3) != 0, pick_op(), pick_op(), $urandom_range(0, 7), rp,
            $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) == 1, $urandom_range(0, 11) == 0,
            $urandom_range(0, 2) != 0, rf);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
